// File: rtl/uart_transmitter.sv
// Purpose : serialises an M-bit word onto a UART line (start 0, M data bits LSB first,
//           optional even-parity bit, stop 1), each bit held CLKS_PER_BIT clocks.
// Latency : first start-bit cycle follows the accepting edge; frame is (M+2)*C clocks,
//           or (M+3)*C when built with UART_TX_PARITY_EN defined (parity bit after data).
// Backpressure: start_in is accepted only while busy_out==0; requests while busy are dropped.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset
//   data_in  - word to send, sampled only on an accepted start
//   start_in - send request
//   bit_out  - registered serial line, idles high
//   busy_out - high for the whole frame (cycle after acceptance to last stop cycle)
//   done_out - one-cycle pulse in the cycle the block returns to idle
module uart_transmitter #(
  parameter int M            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] data_in,
  input  logic         start_in,
  output logic         bit_out,
  output logic         busy_out,
  output logic         done_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [IW-1:0]  r_idx, w_idx_nxt;
  logic [M-1:0]   r_shift, w_shift_nxt;
  logic           r_bit, w_bit_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic           w_bit_last;
`ifdef UART_TX_PARITY_EN
  logic           r_par, w_par_nxt;
`endif

  assign w_bit_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start_in) begin
          w_shift_nxt = data_in;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = ^data_in;
`endif
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // The line is decoded from the next state so bit_out stays a pure register
    // yet changes on the same edge the state does.
    case (w_state_nxt)
      S_START:  w_bit_nxt = 1'b0;
      S_DATA:   w_bit_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_bit_nxt = w_par_nxt;
`endif
      default:  w_bit_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_bit   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign bit_out  = r_bit;
  assign busy_out = r_busy;
  assign done_out = r_done;

endmodule
